// File: rtl/core_run_sequencer.sv
// core_run_sequencer
//
// Purpose:
//   Reset/run sequencer for one or more processor cores. After a start
//   request it holds every core in reset. The hold time is staggered per
//   channel. It then counts run cycles and, unless free-running, finishes
//   in a sticky DONE state. A start request in DONE runs the full
//   sequence again. Abort drops the sequencer back to IDLE.
//
// Parameters:
//   N_CHAN        number of core reset outputs
//   RST_CYCLES    hold cycles for channel 0 (>= 1)
//   STAGGER       extra hold cycles per channel index
//   RUN_CYCLES    cycles spent in RUN before DONE; 0 = free-run
//   HOLD_ON_DONE  1 = put all cores back into reset on entering DONE
//   CNT_WIDTH     width of the hold and run counters
//
// Ports:
//   i_clk          processor clock, rising edge
//   i_rst          synchronous active-low reset
//   i_start        start/restart request (honoured in IDLE and DONE)
//   i_abort        return to IDLE with all cores held in reset
//   o_core_rst     registered active-high reset, one bit per core
//   o_running      high while in RUN
//   o_done         sticky high in DONE
//   o_cycle_count  registered run-cycle count

module core_run_sequencer #(
    parameter int N_CHAN       = 1,
    parameter int RST_CYCLES   = 5,
    parameter int STAGGER      = 0,
    parameter int RUN_CYCLES   = 125,
    parameter int HOLD_ON_DONE = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    output logic [N_CHAN-1:0]    o_core_rst,
    output logic                 o_running,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        DONE
    } state_t;

    localparam longint MAX_CNT   = (longint'(1) << CNT_WIDTH) - 1;
    localparam longint LAST_HOLD = longint'(RST_CYCLES)
                                 + longint'(N_CHAN - 1) * longint'(STAGGER);

    // The last channel to be released is also the one that starts RUN.
    localparam logic [CNT_WIDTH-1:0] LAST_THR = CNT_WIDTH'(LAST_HOLD);
    localparam logic [CNT_WIDTH-1:0] RUN_LAST = CNT_WIDTH'(RUN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RUN_END  = CNT_WIDTH'(RUN_CYCLES);

    if (RST_CYCLES < 1) begin : g_chk_rst_cycles
        $error("core_run_sequencer: RST_CYCLES must be >= 1");
    end
    if (LAST_HOLD > MAX_CNT) begin : g_chk_hold_width
        $error("core_run_sequencer: CNT_WIDTH too small for the longest hold");
    end
    if (longint'(RUN_CYCLES) > MAX_CNT) begin : g_chk_run_width
        $error("core_run_sequencer: CNT_WIDTH too small for RUN_CYCLES");
    end

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  h;
    logic [CNT_WIDTH-1:0]  h_next;
    logic [CNT_WIDTH-1:0]  h_inc;
    logic [N_CHAN-1:0]     core_rst_next;
    logic                  running_next;
    logic                  done_next;
    logic [CNT_WIDTH-1:0]  count_next;

    assign h_inc = h + 1'b1;

    // State and output registers. All outputs are registered, so no input
    // reaches an output combinationally.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state         <= IDLE;
            h             <= '0;
            o_core_rst    <= '1;
            o_running     <= 1'b0;
            o_done        <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            state         <= state_next;
            h             <= h_next;
            o_core_rst    <= core_rst_next;
            o_running     <= running_next;
            o_done        <= done_next;
            o_cycle_count <= count_next;
        end
    end

    // Next-state and next-output logic. Abort takes priority over
    // everything, including a start request in the same cycle.
    always_comb begin
        state_next    = state;
        h_next        = h;
        core_rst_next = o_core_rst;
        running_next  = o_running;
        done_next     = o_done;
        count_next    = o_cycle_count;

        if (i_abort) begin
            state_next    = IDLE;
            h_next        = '0;
            core_rst_next = '1;
            running_next  = 1'b0;
            done_next     = 1'b0;
            count_next    = '0;
        end else begin
            case (state)
                IDLE: begin
                    h_next        = '0;
                    core_rst_next = '1;
                    running_next  = 1'b0;
                    done_next     = 1'b0;
                    count_next    = '0;
                    if (i_start) begin
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    // h only rises, so each channel matches its threshold
                    // once. Once a channel has cleared, it stays cleared.
                    h_next = h_inc;
                    for (int k = 0; k < N_CHAN; k++) begin
                        if (h_inc == CNT_WIDTH'(RST_CYCLES + k * STAGGER)) begin
                            core_rst_next[k] = 1'b0;
                        end
                    end
                    if (h_inc == LAST_THR) begin
                        state_next   = RUN;
                        running_next = 1'b1;
                        count_next   = '0;
                    end
                end
                RUN: begin
                    // In free-run mode the count wraps without raising DONE.
                    count_next = o_cycle_count + 1'b1;
                    if (RUN_CYCLES != 0 && o_cycle_count == RUN_LAST) begin
                        state_next   = DONE;
                        running_next = 1'b0;
                        done_next    = 1'b1;
                        count_next   = RUN_END;
                        if (HOLD_ON_DONE != 0) begin
                            core_rst_next = '1;
                        end
                    end
                end
                DONE: begin
                    if (i_start) begin
                        state_next    = HOLD;
                        h_next        = '0;
                        core_rst_next = '1;
                        done_next     = 1'b0;
                        count_next    = '0;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    h_next        = '0;
                    core_rst_next = '1;
                    running_next  = 1'b0;
                    done_next     = 1'b0;
                    count_next    = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_sequencer.sv
// tb_core_run_sequencer
//
// Purpose:
//   Directed bench for core_run_sequencer. Four instances are built, one
//   for each parameter set of interest. They share the clock and inputs.
//   Each scenario starts from reset and checks only the instance it targets.
//   Instance a: defaults (1 channel, hold 5, run 125, hold on done).
//   Instance b: 3 channels, hold 5, stagger 2.
//   Instance c: free-run, 4-bit counter.
//   Instance d: run 8 cycles, cores left running in DONE.

module tb_core_run_sequencer;

    logic clk;
    logic rst;
    logic start;
    logic abort;

    logic [0:0]  a_core_rst;
    logic        a_running;
    logic        a_done;
    logic [15:0] a_count;

    logic [2:0]  b_core_rst;
    logic        b_running;
    logic        b_done;
    logic [15:0] b_count;

    logic [0:0]  c_core_rst;
    logic        c_running;
    logic        c_done;
    logic [3:0]  c_count;

    logic [0:0]  d_core_rst;
    logic        d_running;
    logic        d_done;
    logic [15:0] d_count;

    int tests_run;
    int tests_failed;

    core_run_sequencer u_dut_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .o_core_rst    (a_core_rst),
        .o_running     (a_running),
        .o_done        (a_done),
        .o_cycle_count (a_count)
    );

    core_run_sequencer #(
        .N_CHAN     (3),
        .RST_CYCLES (5),
        .STAGGER    (2),
        .RUN_CYCLES (10)
    ) u_dut_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .o_core_rst    (b_core_rst),
        .o_running     (b_running),
        .o_done        (b_done),
        .o_cycle_count (b_count)
    );

    core_run_sequencer #(
        .RUN_CYCLES (0),
        .CNT_WIDTH  (4)
    ) u_dut_c (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .o_core_rst    (c_core_rst),
        .o_running     (c_running),
        .o_done        (c_done),
        .o_cycle_count (c_count)
    );

    core_run_sequencer #(
        .RUN_CYCLES   (8),
        .HOLD_ON_DONE (0)
    ) u_dut_d (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .o_core_rst    (d_core_rst),
        .o_running     (d_running),
        .o_done        (d_done),
        .o_cycle_count (d_count)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs and let one rising edge sample them. The
    // task returns shortly after that edge, so the outputs are settled.
    task automatic applyStimulus(input logic rst_v, input logic start_v,
                                 input logic abort_v);
        rst   = rst_v;
        start = start_v;
        abort = abort_v;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;

        // Scenario 1: default timing, a full sequence and a sticky DONE.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst core_rst", a_core_rst, 1);
        checkOutput("rst running", a_running, 0);
        checkOutput("rst done", a_done, 0);
        checkOutput("rst count", a_count, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("idle core_rst", a_core_rst, 1);

        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t1 T core_rst", a_core_rst, 1);
        checkOutput("t1 T running", a_running, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1 T+4 core_rst", a_core_rst, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1 T+5 core_rst", a_core_rst, 0);
        checkOutput("t1 T+5 running", a_running, 1);
        checkOutput("t1 T+5 count", a_count, 0);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            n++;
            if (n == 60) checkOutput("t1 mid count", a_count, 60);
        end while (a_running && n < 200);
        checkOutput("t1 run length", n, 125);
        checkOutput("t1 done", a_done, 1);
        checkOutput("t1 done count", a_count, 125);
        checkOutput("t1 done core_rst", a_core_rst, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1 sticky done", a_done, 1);
        checkOutput("t1 held count", a_count, 125);
        checkOutput("t1 held running", a_running, 0);

        // Scenario 2: staggered release on three channels.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t2 T chan", b_core_rst, 3'b111);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("t2 chan", b_core_rst,
                        (i < 5) ? 3'b111 : (i < 7) ? 3'b110 : (i < 9) ? 3'b100 : 3'b000);
            checkOutput("t2 running", b_running, (i == 9) ? 1 : 0);
        end
        checkOutput("t2 count", b_count, 0);

        // Scenario 3: free-run wraps the 4-bit counter and never finishes.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3 entry count", c_count, 0);
        checkOutput("t3 entry running", c_running, 1);
        for (int i = 1; i <= 19; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("t3 count", c_count, i % 16);
        end
        checkOutput("t3 done", c_done, 0);
        checkOutput("t3 running", c_running, 1);

        // Scenario 4: abort in RUN, then abort overrides start.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4 pre-abort count", a_count, 40);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t4 abort core_rst", a_core_rst, 1);
        checkOutput("t4 abort running", a_running, 0);
        checkOutput("t4 abort count", a_count, 0);
        checkOutput("t4 abort done", a_done, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4 start+abort core_rst", a_core_rst, 1);
        checkOutput("t4 start+abort running", a_running, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4 restart T+4 core_rst", a_core_rst, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4 restart T+5 core_rst", a_core_rst, 0);
        checkOutput("t4 restart T+5 running", a_running, 1);

        // Scenario 5: reset mid-HOLD, start ignored in RUN, restart from DONE.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5 rst core_rst", a_core_rst, 1);
        checkOutput("t5 rst running", a_running, 0);
        checkOutput("t5 rst count", a_count, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5 hold T+4 core_rst", a_core_rst, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5 hold T+5 core_rst", a_core_rst, 0);
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t5 run start count", a_count, 4);
        checkOutput("t5 run start running", a_running, 1);
        checkOutput("t5 run start core_rst", a_core_rst, 0);
        n = 4;
        while (a_running && n < 200) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            n++;
        end
        checkOutput("t5 run length", n, 125);
        checkOutput("t5 done", a_done, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t5 restart done", a_done, 0);
        checkOutput("t5 restart core_rst", a_core_rst, 1);
        checkOutput("t5 restart count", a_count, 0);
        checkOutput("t5 restart running", a_running, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5 rehold T+4 core_rst", a_core_rst, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5 rehold T+5 core_rst", a_core_rst, 0);
        checkOutput("t5 rehold T+5 running", a_running, 1);

        // Scenario 6: cores keep running in DONE when HOLD_ON_DONE is 0.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t6 pre-done done", d_done, 0);
        checkOutput("t6 pre-done running", d_running, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t6 done", d_done, 1);
        checkOutput("t6 running", d_running, 0);
        checkOutput("t6 core_rst", d_core_rst, 0);
        checkOutput("t6 count", d_count, 8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
